// File: rtl/branch_predict_unit.sv
// Branch resolution for RV32I conditional branches plus a BHT of 2-bit saturating counters.
// Optional statistics counters are built only when BPU_STATS_EN is defined.
module branch_predict_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned INDEX_LSB   = 2,
  parameter logic [1:0]  CTR_INIT    = 2'b01
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_func3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic            Z,
  input  logic            C,
  input  logic            S,
  input  logic            V,
  output logic            branch_out,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] stat_branches,
  output logic [XLEN-1:0] stat_mispredicts
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } func3_e;

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             resolve;
  logic             legal;
  logic             cond;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             mispredict_d;

  // Only the index bits of the fetch PC participate in lookup.
  logic unused_if_pc;
  assign unused_if_pc = ^if_pc;

  assign if_idx  = if_pc[INDEX_LSB +: IDX_W];
  assign ex_idx  = ex_pc[INDEX_LSB +: IDX_W];
  assign resolve = ex_valid & ex_branch;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (ex_func3)
      F3_BEQ:  cond = Z;
      F3_BNE:  cond = ~Z;
      F3_BLT:  cond = S ^ V;
      F3_BGE:  cond = ~(S ^ V);
      F3_BLTU: cond = ~C;
      F3_BGEU: cond = C;
      default: legal = 1'b0;
    endcase
  end

  assign branch_out   = resolve & cond;
  assign pred_taken   = bht[if_idx][1];
  assign mispredict_d = resolve & (branch_out != ex_pred_taken);

  always_comb begin
    ctr_cur  = bht[ex_idx];
    ctr_next = ctr_cur;
    if (branch_out) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
    end
  end

  // NOTE: the table is reset entry by entry because the predictor must start from a known bias;
  // this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CTR_INIT;
    end else if (resolve && legal) begin
      bht[ex_idx] <= ctr_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= mispredict_d;
      if (mispredict_d) redirect_pc <= branch_out ? ex_target : ex_pc + XLEN'(4);
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (resolve && !(&stat_branches)) stat_branches <= stat_branches + XLEN'(1);
      if (mispredict_d && !(&stat_mispredicts)) stat_mispredicts <= stat_mispredicts + XLEN'(1);
    end
  end
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed self-checking bench for branch_predict_unit (BHT_ENTRIES=64, INDEX_LSB=2, CTR_INIT=01).
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid, ex_branch, ex_pred_taken;
  logic [2:0]  ex_func3;
  logic [31:0] ex_pc, ex_target;
  logic        Z, C, S, V;
  logic        branch_out, mispredict;
  logic [31:0] redirect_pc, stat_branches, stat_mispredicts;

  int checks   = 0;
  int failures = 0;

  branch_predict_unit #(
    .XLEN(32), .BHT_ENTRIES(64), .INDEX_LSB(2), .CTR_INIT(2'b01)
  ) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .ex_valid(ex_valid), .ex_branch(ex_branch), .ex_func3(ex_func3),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
    .Z(Z), .C(C), .S(S), .V(V),
    .branch_out(branch_out), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_branch = 1'b0; ex_func3 = 3'b000; ex_pred_taken = 1'b0;
    ex_pc = '0; ex_target = '0; {Z, C, S, V} = 4'b0000;
  endtask

  task automatic set_ex(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic [3:0] zcsv);
    ex_valid = 1'b1; ex_branch = 1'b1; ex_func3 = f3; ex_pc = pc; ex_target = tgt;
    ex_pred_taken = pred; {Z, C, S, V} = zcsv;
  endtask

  // func3, {Z,C,S,V}, expected branch_out
  typedef struct { logic [2:0] f3; logic [3:0] zcsv; logic exp; } vec_t;
  vec_t tbl [11];

  initial begin
    tbl[0]  = '{3'b000, 4'b0000, 1'b0};
    tbl[1]  = '{3'b001, 4'b0000, 1'b1};
    tbl[2]  = '{3'b100, 4'b0010, 1'b1};
    tbl[3]  = '{3'b100, 4'b0011, 1'b0};
    tbl[4]  = '{3'b101, 4'b0000, 1'b1};
    tbl[5]  = '{3'b101, 4'b0010, 1'b0};
    tbl[6]  = '{3'b110, 4'b0000, 1'b1};
    tbl[7]  = '{3'b110, 4'b0100, 1'b0};
    tbl[8]  = '{3'b111, 4'b0100, 1'b1};
    tbl[9]  = '{3'b111, 4'b0000, 1'b0};
    tbl[10] = '{3'b011, 4'b1111, 1'b0};

    rst = 1'b1; if_pc = '0; idle();
    tick();
    rst = 1'b0;

    // 1. reset state
    if_pc = 32'h000; #1;
    check("rst_pred_0x000", pred_taken, 1'b0);
    if_pc = 32'h0FC; #1;
    check("rst_pred_0x0fc", pred_taken, 1'b0);
    check("rst_mispredict", mispredict, 1'b0);
    check("rst_redirect", redirect_pc, 32'h0);
    check("rst_stat_br", stat_branches, 32'h0);
    check("rst_stat_mp", stat_mispredicts, 32'h0);

    // 2. first taken BEQ mispredicts, ctr[0] 01->10
    if_pc = 32'h100;
    set_ex(3'b000, 32'h100, 32'h180, 1'b0, 4'b1000); #1;
    check("beq_branch_out", branch_out, 1'b1);
    check("beq_pred_old", pred_taken, 1'b0);
    tick();
    idle(); #1;
    check("beq_mispredict", mispredict, 1'b1);
    check("beq_redirect", redirect_pc, 32'h180);
    check("beq_pred_new", pred_taken, 1'b1);
    tick();
    check("pulse_clears", mispredict, 1'b0);
    check("redirect_held", redirect_pc, 32'h180);

    // 3. saturate at 11, then BNE not taken -> 10
    for (int i = 0; i < 4; i++) begin
      set_ex(3'b000, 32'h100, 32'h180, 1'b1, 4'b1000);
      tick();
    end
    check("sat_no_mispredict", mispredict, 1'b0);
    set_ex(3'b001, 32'h100, 32'h180, 1'b1, 4'b1000); #1;
    check("bne_branch_out", branch_out, 1'b0);
    tick();
    idle(); #1;
    check("bne_mispredict", mispredict, 1'b1);
    check("bne_redirect", redirect_pc, 32'h104);
    check("bne_pred_still1", pred_taken, 1'b1);

    // 4. alias through index 0; back-to-back mispredicts
    set_ex(3'b000, 32'h100, 32'h180, 1'b1, 4'b1000);  // 10->11
    tick();
    if_pc = 32'h200;
    set_ex(3'b110, 32'h200, 32'h280, 1'b1, 4'b0100); #1;  // BLTU C=1, not taken
    check("alias_pred", pred_taken, 1'b1);
    check("bltu_branch_out", branch_out, 1'b0);
    tick();  // 11->10
    check("b2b_mp1", mispredict, 1'b1);
    check("b2b_redirect1", redirect_pc, 32'h204);
    if_pc = 32'h100;
    set_ex(3'b111, 32'h300, 32'h380, 1'b1, 4'b0000); #1;  // BGEU C=0, not taken
    check("same_cycle_old", pred_taken, 1'b1);
    tick();  // 10->01
    idle(); #1;
    check("b2b_mp2", mispredict, 1'b1);
    check("b2b_redirect2", redirect_pc, 32'h304);
    check("same_cycle_new", pred_taken, 1'b0);

    // 5. illegal func3 resolves as not taken without touching the BHT
    if_pc = 32'h104;
    set_ex(3'b000, 32'h104, 32'h400, 1'b0, 4'b1000);  // ctr[1] 01->10
    tick();
    set_ex(3'b010, 32'h104, 32'h400, 1'b1, 4'b1111); #1;
    check("illegal_branch_out", branch_out, 1'b0);
    check("illegal_pred_before", pred_taken, 1'b1);
    tick();
    set_ex(3'b011, 32'h104, 32'h400, 1'b1, 4'b1111);
    tick();
    idle(); #1;
    check("illegal_mispredict", mispredict, 1'b1);
    check("illegal_redirect", redirect_pc, 32'h108);
    check("illegal_ctr_kept", pred_taken, 1'b1);

    // condition table evaluated under reset so no state changes
    rst = 1'b1;
    foreach (tbl[k]) begin
      set_ex(tbl[k].f3, 32'h500, 32'h600, 1'b0, tbl[k].zcsv); #1;
      check($sformatf("cond_%0d", k), branch_out, tbl[k].exp);
      tick();
    end
    set_ex(3'b000, 32'h500, 32'h600, 1'b0, 4'b1000); ex_branch = 1'b0; #1;
    check("no_branch_out", branch_out, 1'b0);
    ex_branch = 1'b1; ex_valid = 1'b0; #1;
    check("no_valid_out", branch_out, 1'b0);
    tick();
    rst = 1'b0;

    // 6. reset wins over a mispredicting resolve
    tick();
    if_pc = 32'h104;
    set_ex(3'b000, 32'h104, 32'h400, 1'b0, 4'b1000);  // ctr[1] 01->10 without the reset
    tick();
    set_ex(3'b000, 32'h104, 32'h400, 1'b0, 4'b1000);
    rst = 1'b1;
    tick();
    rst = 1'b0; idle(); #1;
    check("rst_win_mispredict", mispredict, 1'b0);
    check("rst_win_redirect", redirect_pc, 32'h0);
    check("rst_win_ctr", pred_taken, 1'b0);

    // 10 resolves, 3 mispredicts, one non-branch in between
    for (int i = 0; i < 10; i++) begin
      set_ex(3'b000, 32'h108, 32'h700, (i % 3 == 1), 4'b0000);
      tick();
      if (i == 4) begin
        set_ex(3'b000, 32'h108, 32'h700, 1'b1, 4'b0000); ex_branch = 1'b0;
        tick();
      end
    end
    idle(); #1;
`ifdef BPU_STATS_EN
    check("stat_branches", stat_branches, 32'd10);
    check("stat_mispredicts", stat_mispredicts, 32'd3);
`else
    check("stat_branches", stat_branches, 32'd0);
    check("stat_mispredicts", stat_mispredicts, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
